fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer.sv | 149 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, buffers fetched words in a
// 2-entry FIFO toward decode, and handles redirects, the halt sentinel and range faults.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 65536,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {IDLE, FETCH, HALT, FAULT} state_t;

    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] head_pc, head_instr, tail_pc, tail_instr;
    logic [1:0]  count;
    logic        deq, enq, flush, can_enq;
    logic [31:0] redirect_aligned;

    assign imem_addr        = pc;
    assign out_valid        = (count != 2'd0);
    assign out_pc           = head_pc;
    assign out_instr        = head_instr;
    assign deq              = out_valid & out_ready;
    assign can_enq          = (count < 2'd2) | ((count == 2'd2) & deq);
    assign halted           = (state == HALT) && (count == 2'd0);
    assign fault            = (state == FAULT);
    assign redirect_aligned = redirect_pc & ~32'd3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Redirect outranks fault, halt detection and enqueue in both FETCH and HALT.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        enq        = 1'b0;
        flush      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                    pc_next    = RESET_PC;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    flush   = 1'b1;
                    pc_next = redirect_aligned;
                end else if (can_enq) begin
                    if (pc > LAST_ADDR) begin
                        state_next = FAULT;
                    end else if (imem_data == HALT_WORD) begin
                        state_next = HALT;
                    end else begin
                        enq     = 1'b1;
                        pc_next = pc + 32'd4;
                    end
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    pc_next    = redirect_aligned;
                    state_next = FETCH;
                end
            end
            FAULT: begin
            end
            default: state_next = IDLE;
        endcase
    end

    // Head always at entry 0; a dequeue shifts the tail forward so order is kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count      <= 2'd0;
            head_pc    <= 32'd0;
            head_instr <= 32'd0;
            tail_pc    <= 32'd0;
            tail_instr <= 32'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({enq, deq})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_pc    <= pc;
                        head_instr <= imem_data;
                        count      <= 2'd1;
                    end else begin
                        tail_pc    <= pc;
                        tail_instr <= imem_data;
                        count      <= 2'd2;
                    end
                end
                2'b01: begin
                    head_pc    <= tail_pc;
                    head_instr <= tail_instr;
                    count      <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_pc    <= pc;
                        head_instr <= imem_data;
                    end else begin
                        head_pc    <= tail_pc;
                        head_instr <= tail_instr;
                        tail_pc    <= pc;
                        tail_instr <= imem_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count <= 32'd0;
        end else if (deq) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sentinel program, backpressure, redirect,
// halt/resume, range fault and asynchronous reset, each step checked by assertion.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:16383];
    logic [31:0] dq_pc[$];
    logic [31:0] dq_instr[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_data = (imem_addr < 32'h0001_0000) ? mem[imem_addr[15:2]] : 32'h0;

    fetch_sequencer dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .halted(halted),
        .fault(fault),
        .fetch_count(fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Records the head if it is accepted at the coming edge, then advances one cycle.
    task automatic cycle();
        if (out_valid && out_ready) begin
            dq_pc.push_back(out_pc);
            dq_instr.push_back(out_instr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        dq_pc.delete();
        dq_instr.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        cycle();
        redirect_valid = 1'b0;
    endtask

    function automatic logic [31:0] pc_at(int i);
        return (dq_pc.size() > i) ? dq_pc[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] instr_at(int i);
        return (dq_instr.size() > i) ? dq_instr[i] : 32'hxxxx_xxxx;
    endfunction

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0200_0093 + 32'(i);
        mem[13] = 32'hFFFF_FFFF;

        // Reset values
        do_reset();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_fetch_count", fetch_count, 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);

        // Sentinel program: 13 words then HALT_WORD at byte 52
        out_ready = 1'b1;
        pulse_start();
        check("latency_not_yet", {31'd0, out_valid}, 32'd0);
        cycle();
        check("latency_first_valid", {31'd0, out_valid}, 32'd1);
        for (int n = 0; n < 40 && !halted; n++) cycle();
        check("sent_halted", {31'd0, halted}, 32'd1);
        check("sent_count", 32'(dq_pc.size()), 32'd13);
        check("sent_first_instr", instr_at(0), 32'h0200_0093);
        for (int i = 0; i < 13; i++) begin
            check($sformatf("sent_pc_%0d", i), pc_at(i), 32'(4 * i));
            check($sformatf("sent_instr_%0d", i), instr_at(i), 32'h0200_0093 + 32'(i));
        end
        check("sent_fetch_count", fetch_count, 32'd13);
        check("sent_pc_held", imem_addr, 32'd52);

        // Backpressure
        do_reset();
        pulse_start();
        for (int n = 0; n < 10; n++) cycle();
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_head_pc", out_pc, 32'd0);
        check("bp_head_instr", out_instr, 32'h0200_0093);
        check("bp_imem_addr", imem_addr, 32'd8);
        check("bp_fetch_count", fetch_count, 32'd0);
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) cycle();
        check("bp_count", 32'(dq_pc.size()), 32'd3);
        check("bp_pc0", pc_at(0), 32'd0);
        check("bp_pc1", pc_at(1), 32'd4);
        check("bp_pc2", pc_at(2), 32'd8);
        check("bp_instr2", instr_at(2), 32'h0200_0095);

        // Redirect with two entries queued
        do_reset();
        pulse_start();
        for (int n = 0; n < 4; n++) cycle();
        check("rd_pre_addr", imem_addr, 32'd8);
        pulse_redirect(32'h0000_0023);
        check("rd_flushed", {31'd0, out_valid}, 32'd0);
        check("rd_imem_addr", imem_addr, 32'h20);
        out_ready = 1'b1;
        dq_pc.delete();
        dq_instr.delete();
        for (int n = 0; n < 10 && dq_pc.size() < 2; n++) cycle();
        check("rd_first_pc", pc_at(0), 32'h20);
        check("rd_second_pc", pc_at(1), 32'h24);
        check("rd_fetch_count", fetch_count, 32'd2);

        // Halt then resume
        for (int n = 0; n < 40 && !halted; n++) cycle();
        check("hr_halted", {31'd0, halted}, 32'd1);
        pulse_redirect(32'h10);
        check("hr_unhalted", {31'd0, halted}, 32'd0);
        check("hr_imem_addr", imem_addr, 32'h10);
        dq_pc.delete();
        dq_instr.delete();
        for (int n = 0; n < 10 && dq_pc.size() < 1; n++) cycle();
        check("hr_first_pc", pc_at(0), 32'h10);
        check("hr_first_instr", instr_at(0), 32'h0200_0097);

        // Fault past the last legal word
        pulse_redirect(32'h0000_FFFE);
        check("flt_aligned", imem_addr, 32'h0000_FFFC);
        dq_pc.delete();
        dq_instr.delete();
        for (int n = 0; n < 10 && !fault; n++) cycle();
        check("flt_fault", {31'd0, fault}, 32'd1);
        for (int n = 0; n < 3; n++) cycle();
        check("flt_count", 32'(dq_pc.size()), 32'd1);
        check("flt_last_pc", pc_at(0), 32'h0000_FFFC);
        check("flt_no_valid", {31'd0, out_valid}, 32'd0);
        pulse_redirect(32'h0);
        check("flt_redirect_ignored", {31'd0, fault}, 32'd1);
        check("flt_addr_held", imem_addr, 32'h0001_0000);
        #2;
        reset_n = 1'b0;
        #1;
        check("flt_reset_clears", {31'd0, fault}, 32'd0);

        // Asynchronous reset mid-run
        do_reset();
        pulse_start();
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) cycle();
        out_ready = 1'b0;
        for (int n = 0; n < 2; n++) cycle();
        check("ar_pre_count", fetch_count, 32'd2);
        check("ar_pre_head", out_pc, 32'd8);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_out_valid", {31'd0, out_valid}, 32'd0);
        check("ar_fetch_count", fetch_count, 32'd0);
        check("ar_out_pc", out_pc, 32'd0);
        check("ar_imem_addr", imem_addr, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) cycle();
        check("ar_idle_no_fetch", {31'd0, out_valid}, 32'd0);
        pulse_start();
        cycle();
        check("ar_restart_valid", {31'd0, out_valid}, 32'd1);
        check("ar_restart_pc", out_pc, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
